// File: rtl/ha_frame_accumulator_if.sv
// Handshake bundle between the half-adder sample source, the frame accumulator
// and the result consumer.
interface ha_frame_accumulator_if #(
   parameter int SUM_W = 8
);
   logic             start;
   logic             in_valid;
   logic             and_i;
   logic             xor_i;
   logic             out_valid;
   logic             out_ready;
   logic [SUM_W-1:0] sum_o;
   logic             err_o;
   logic             sat_o;
   logic             busy_o;

   modport master (
      output start, in_valid, and_i, xor_i, out_ready,
      input  out_valid, sum_o, err_o, sat_o, busy_o
   );

   modport slave (
      input  start, in_valid, and_i, xor_i, out_ready,
      output out_valid, sum_o, err_o, sat_o, busy_o
   );
endinterface

// File: rtl/ha_frame_accumulator.sv
// Sums {carry,sum} half-adder samples over FRAME_LEN accepted samples and
// hands the saturating total downstream over valid/ready, with sticky error flags.
module ha_frame_accumulator #(
   parameter int SUM_W     = 8,
   parameter int FRAME_LEN = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   ha_frame_accumulator_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   localparam logic [SUM_W-1:0] ACC_MAX  = {SUM_W{1'b1}};
   localparam logic [7:0]       LAST_CNT = 8'(FRAME_LEN - 1);

   state_t           state_q, state_d;
   logic [SUM_W-1:0] acc_q, acc_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             sat_q, sat_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic [SUM_W:0]   contrib;
   logic [SUM_W:0]   sum_ext;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      sat_d   = sat_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      contrib = '0;
      sum_ext = '0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = ACCUM;
               acc_d   = '0;
               cnt_d   = '0;
               err_d   = 1'b0;
               sat_d   = 1'b0;
               busy_d  = 1'b1;
            end
         end
         ACCUM: begin
            if (bus.in_valid) begin
               // (1,1) cannot come out of a half adder: flag it and add nothing
               if (bus.and_i && bus.xor_i) begin
                  err_d = 1'b1;
               end else begin
                  contrib[1] = bus.and_i;
                  contrib[0] = bus.xor_i;
               end
               sum_ext = {1'b0, acc_q} + contrib;
               if (sum_ext[SUM_W]) begin
                  acc_d = ACC_MAX;
                  sat_d = 1'b1;
               end else begin
                  acc_d = sum_ext[SUM_W-1:0];
               end
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == LAST_CNT) begin
                  state_d = DONE;
                  valid_d = 1'b1;
                  busy_d  = 1'b0;
               end
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               valid_d = 1'b0;
               if (bus.start) begin
                  state_d = ACCUM;
                  acc_d   = '0;
                  cnt_d   = '0;
                  err_d   = 1'b0;
                  sat_d   = 1'b0;
                  busy_d  = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         sat_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         sat_q   <= sat_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.out_valid = valid_q;
   assign bus.sum_o     = acc_q;
   assign bus.err_o     = err_q;
   assign bus.sat_o     = sat_q;
   assign bus.busy_o    = busy_q;
endmodule

// File: tb/tb_ha_frame_accumulator.sv
// Two accumulator instances (8-bit/8-sample and 3-bit/4-sample) share one input
// stream; a per-instance frame model checks them every cycle.
module tb_ha_frame_accumulator;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0, in_valid = 1'b0, and_i = 1'b0, xor_i = 1'b0, out_ready = 1'b0;
   int   checks = 0, failures = 0;
   bit   chk_en = 1'b0;

   always #5 clk = ~clk;

   ha_frame_accumulator_if #(.SUM_W(8)) ifa ();
   ha_frame_accumulator_if #(.SUM_W(3)) ifb ();

   assign ifa.start = start;  assign ifa.in_valid = in_valid;
   assign ifa.and_i = and_i;  assign ifa.xor_i = xor_i;  assign ifa.out_ready = out_ready;
   assign ifb.start = start;  assign ifb.in_valid = in_valid;
   assign ifb.and_i = and_i;  assign ifb.xor_i = xor_i;  assign ifb.out_ready = out_ready;

   ha_frame_accumulator #(.SUM_W(8), .FRAME_LEN(8)) u_a (.clk(clk), .rst(rst), .bus(ifa));
   ha_frame_accumulator #(.SUM_W(3), .FRAME_LEN(4)) u_b (.clk(clk), .rst(rst), .bus(ifb));

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
      end
   endtask

   // Model: 0=waiting for start, 1=collecting, 2=result offered
   int m_st[2], m_acc[2], m_cnt[2], m_err[2], m_sat[2];
   int MAXV[2] = '{255, 7};
   int FL[2]   = '{8, 4};

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_st[i] = 0; m_acc[i] = 0; m_cnt[i] = 0; m_err[i] = 0; m_sat[i] = 0;
         end else if (m_st[i] == 0 || (m_st[i] == 2 && out_ready)) begin
            if (start) begin
               m_st[i] = 1; m_acc[i] = 0; m_cnt[i] = 0; m_err[i] = 0; m_sat[i] = 0;
            end else begin
               m_st[i] = 0;
            end
         end else if (m_st[i] == 1 && in_valid) begin
            int c;
            c = (and_i && xor_i) ? 0 : 2 * int'(and_i) + int'(xor_i);
            if (and_i && xor_i) m_err[i] = 1;
            if (m_acc[i] + c > MAXV[i]) begin
               m_acc[i] = MAXV[i];
               m_sat[i] = 1;
            end else begin
               m_acc[i] = m_acc[i] + c;
            end
            m_cnt[i]++;
            if (m_cnt[i] == FL[i]) m_st[i] = 2;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("a_valid", int'(ifa.out_valid), int'(m_st[0] == 2));
         chk("a_busy",  int'(ifa.busy_o),    int'(m_st[0] == 1));
         chk("b_valid", int'(ifb.out_valid), int'(m_st[1] == 2));
         chk("b_busy",  int'(ifb.busy_o),    int'(m_st[1] == 1));
         if (m_st[0] != 1) begin
            chk("a_sum", int'(ifa.sum_o), m_acc[0]);
            chk("a_err", int'(ifa.err_o), m_err[0]);
            chk("a_sat", int'(ifa.sat_o), m_sat[0]);
         end
         if (m_st[1] != 1) begin
            chk("b_sum", int'(ifb.sum_o), m_acc[1]);
            chk("b_err", int'(ifb.err_o), m_err[1]);
            chk("b_sat", int'(ifb.sat_o), m_sat[1]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input bit v, input bit a, input bit x);
      in_valid = v; and_i = a; xor_i = x;
      step();
      in_valid = 1'b0;
   endtask

   task automatic begin_frame();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      bit [1:0] tt [4] = '{2'b00, 2'b01, 2'b01, 2'b10};
      bit [1:0] ill[4] = '{2'b11, 2'b01, 2'b10, 2'b00};
      step(); step();
      rst = 1'b0;
      chk_en = 1'b1;
      chk("rst_valid", int'(ifa.out_valid), 0);
      chk("rst_sum",   int'(ifa.sum_o), 0);
      chk("rst_busy",  int'(ifa.busy_o), 0);

      // Truth-table frame
      begin_frame();
      chk("tt_busy_start", int'(ifa.busy_o), 1);
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < 4; k++) sample(1'b1, tt[k][1], tt[k][0]);
      chk("tt_valid", int'(ifa.out_valid), 1);
      chk("tt_busy",  int'(ifa.busy_o), 0);
      chk("tt_sum",   int'(ifa.sum_o), 8);
      chk("tt_err",   int'(ifa.err_o), 0);
      chk("tt_sat",   int'(ifa.sat_o), 0);
      handshake();
      chk("tt_idle_valid", int'(ifa.out_valid), 0);
      chk("tt_idle_sum",   int'(ifa.sum_o), 8);

      // Gapped frame with junk payload on idle cycles
      begin_frame();
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < 4; k++) begin
            sample(1'b1, tt[k][1], tt[k][0]);
            if (!(r == 1 && k == 3)) sample(1'b0, 1'b1, 1'b0);
         end
      chk("gap_sum", int'(ifa.sum_o), 8);
      chk("gap_valid", int'(ifa.out_valid), 1);

      // Backpressure, then back-to-back start
      for (int k = 0; k < 5; k++) begin
         sample(k[0], 1'b1, 1'b0);
         chk("bp_valid", int'(ifa.out_valid), 1);
         chk("bp_sum",   int'(ifa.sum_o), 8);
      end
      start = 1'b1; out_ready = 1'b1;
      step();
      start = 1'b0; out_ready = 1'b0;
      chk("b2b_busy",  int'(ifa.busy_o), 1);
      chk("b2b_valid", int'(ifa.out_valid), 0);
      for (int k = 0; k < 8; k++) sample(1'b1, k[0], ~k[0]);
      chk("b2b_sum", int'(ifa.sum_o), 12);
      handshake();
      do_reset();

      // Illegal pair, then a clean frame, on the 4-sample instance
      begin_frame();
      for (int k = 0; k < 4; k++) sample(1'b1, ill[k][1], ill[k][0]);
      chk("ill_sum", int'(ifb.sum_o), 3);
      chk("ill_err", int'(ifb.err_o), 1);
      chk("ill_sat", int'(ifb.sat_o), 0);
      handshake();
      begin_frame();
      for (int k = 0; k < 4; k++) sample(1'b1, 1'b0, 1'b1);
      chk("clean_err", int'(ifb.err_o), 0);
      chk("clean_sum", int'(ifb.sum_o), 4);
      handshake();

      // Saturation of the 3-bit accumulator
      begin_frame();
      for (int k = 0; k < 4; k++) sample(1'b1, 1'b1, 1'b0);
      chk("sat_sum", int'(ifb.sum_o), 7);
      chk("sat_sat", int'(ifb.sat_o), 1);
      handshake();
      do_reset();

      // Reset mid-frame
      begin_frame();
      for (int k = 0; k < 3; k++) sample(1'b1, 1'b1, 1'b0);
      do_reset();
      chk("mid_rst_busy",  int'(ifa.busy_o), 0);
      chk("mid_rst_valid", int'(ifa.out_valid), 0);
      chk("mid_rst_sum",   int'(ifa.sum_o), 0);
      begin_frame();
      for (int k = 0; k < 8; k++) sample(1'b1, 1'b0, 1'b1);
      chk("post_rst_sum", int'(ifa.sum_o), 8);
      handshake();

      // Random traffic against the model
      for (int n = 0; n < 600; n++) begin
         rst       = ($urandom_range(0, 79) == 0);
         start     = ($urandom_range(0, 3) == 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         and_i     = 1'($urandom);
         xor_i     = 1'($urandom);
         out_ready = ($urandom_range(0, 2) == 0);
         step();
      end
      rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      step();
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
